// File: rtl/mfp_uart_pkg.sv
// Shared definitions for the mfp UART blocks: frame FSM encoding and bit-period arithmetic.
package mfp_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int calc_divisor(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is readable combinationally
// so the consumer can pop and use the data on the same edge.
module mfp_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mfp_sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// FIFO-buffered 8N1 UART transmitter; frames are sent back-to-back while the FIFO holds data.
module mfp_uart_transmitter
    import mfp_uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int BW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_fifo_head;
    logic          w_baud_done;
    logic          w_pop;

    mfp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (byte_valid),
        .push_data (byte_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    // A new frame may start from IDLE or directly out of the last STOP cycle.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || (r_state == ST_STOP && w_baud_done));

    assign byte_ready = !w_fifo_full;
    assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
    assign tx         = r_tx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_head;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= w_fifo_head;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
                            r_state   <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Scoreboard bench for mfp_uart_transmitter at DIVISOR=16: accepted bytes are queued,
// a line monitor checks every received frame cycle-by-cycle against the queue head.
`timescale 1ns/1ps
module tb_mfp_uart_transmitter;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    mfp_uart_transmitter #(
        .CLOCK_FREQUENCY (16),
        .BAUD_RATE       (1),
        .FIFO_DEPTH      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int start_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic expected_bit(input logic [7:0] b, input int c);
        if (c < DIV) return 1'b0;
        if (c < 9 * DIV) return b[(c - DIV) / DIV];
        return 1'b1;
    endfunction

    function automatic int slog(input int i);
        return (start_log.size() > i) ? start_log[i] : -1;
    endfunction

    // Line monitor: a frame begins at the first low sample on an idle line.
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       has_exp;
        int         bad_c;
        int         frame_no;
        int         start_cyc;
        bit         aborted;
        frame_no = 0;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                start_cyc = cyc;
                start_log.push_back(start_cyc);
                has_exp = (exp_q.size() > 0);
                exp_b   = has_exp ? exp_q[0] : 8'h00;
                bad_c   = -1;
                got     = 8'h00;
                aborted = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) begin
                        @(negedge clock);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2) got[c / DIV - 1] = tx;
                    if (tx !== expected_bit(exp_b, c) && bad_c < 0) bad_c = c;
                end
                if (aborted) begin
                    $display("frame %0d: start@%0d aborted by reset", frame_no, start_cyc);
                end else begin
                    check("frame_expected", 32'(has_exp), 32'd1);
                    if (has_exp) void'(exp_q.pop_front());
                    check("frame_byte", 32'(got), 32'(exp_b));
                    check("frame_first_bad_cycle", bad_c, -1);
                    $display("frame %0d: start@%0d got 0x%02h want 0x%02h", frame_no, start_cyc, got, exp_b);
                end
                frame_no++;
            end
        end
    end

    // Presents a byte for one edge; leaves byte_valid high so calls can run back-to-back.
    task automatic offer(input logic [7:0] b, output bit acc, output int edge_no);
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = b;
        acc        = byte_ready;
        @(posedge clock);
        #1;
        edge_no = cyc;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic drop();
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int fall);
        fall = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!busy) begin
                fall = cyc;
                break;
            end
        end
        n_checks++;
        if (fall < 0) $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", limit);
        else n_pass++;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e, e2, f, n_acc;
        bit acc;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single byte latency and frame length.
        start_log.delete();
        offer(8'h55, acc, e);
        drop();
        check("t1_accept", 32'(acc), 32'd1);
        check("t1_count_after_push", 32'(fifo_count), 32'd1);
        @(negedge clock);
        check("t1_tx_before_pop", 32'(tx), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_tx_start_low", 32'(tx), 32'd0);
        check("t1_count_after_pop", 32'(fifo_count), 32'd0);
        wait_idle(400, f);
        check("t1_busy_fall_edge", f, e + 161);
        check("t1_start_edge", slog(0), e + 1);

        // Three back-to-back bytes: contiguous frames.
        start_log.delete();
        offer(8'h01, acc, e);
        check("t2_count_a", 32'(fifo_count), 32'd1);
        offer(8'h02, acc, e2);
        check("t2_count_b", 32'(fifo_count), 32'd1);
        offer(8'h03, acc, e2);
        check("t2_count_c", 32'(fifo_count), 32'd2);
        drop();
        wait_idle(800, f);
        check("t2_busy_fall_edge", f, e + 481);
        check("t2_frames", start_log.size(), 3);
        check("t2_gap_1", slog(1) - slog(0), FRAME);
        check("t2_gap_2", slog(2) - slog(1), FRAME);

        // Continuous offers until full: 17 accepted, the rest dropped.
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            offer(8'(8'h10 + i), acc, e2);
            check("t3_ready", 32'(acc), (i < 17) ? 32'd1 : 32'd0);
            n_acc += int'(acc);
        end
        drop();
        check("t3_accepted", n_acc, 17);
        check("t3_count_full", 32'(fifo_count), 32'd16);
        check("t3_ready_low", 32'(byte_ready), 32'd0);
        wait_idle(17 * FRAME + 100, f);
        check("t3_queue_drained", exp_q.size(), 0);

        // Asynchronous reset 40 cycles into a frame with three bytes queued.
        start_log.delete();
        offer(8'hA5, acc, e);
        offer(8'hB1, acc, e2);
        offer(8'hB2, acc, e2);
        offer(8'hB3, acc, e2);
        drop();
        while (cyc < e + 41) @(negedge clock);
        check("t4_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t4_rst_tx", 32'(tx), 32'd1);
        check("t4_rst_count", 32'(fifo_count), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_ready", 32'(byte_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        start_log.delete();
        offer(8'h3C, acc, e);
        drop();
        wait_idle(400, f);
        check("t4_busy_fall_edge", f, e + 161);
        check("t4_start_edge", slog(0), e + 1);
        check("t4_frames", start_log.size(), 1);

        // Push during the STOP bit of the last queued frame.
        start_log.delete();
        offer(8'h81, acc, e);
        drop();
        while (cyc < e + 151) @(negedge clock);
        check("t5_tx_stop", 32'(tx), 32'd1);
        offer(8'h7E, acc, e2);
        drop();
        wait_idle(600, f);
        check("t5_frames", start_log.size(), 2);
        check("t5_gap", slog(1) - slog(0), FRAME);
        check("t5_busy_fall_edge", f, e + 321);

        repeat (5) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
